controller: RTL and testbench
=============================

# controller

Instruction sequencer for the 8-bit RISC core. It steps through a fixed eight-phase fetch/execute cycle and drives the load, select, read/write and increment strobes of the program counter, instruction register, accumulator, memory and address mux, all of which are built from the shared `Register` and counter blocks. The decode is Moore-style: outputs are a function of the registered phase, the current opcode from the instruction register, and the ALU zero flag.

## Interface

- Parameters: none. The opcode width is fixed at 3 bits and the phase count is fixed at 8.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 3: opcode field from the instruction register output.
- `zero` in 1: accumulator-zero flag from the ALU.
- `sel` out 1: address mux select. 1 selects the PC; 0 selects the IR operand.
- `rd` out 1: memory read enable.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: PC increment.
- `ld_pc` out 1: PC load from the IR operand.
- `ld_ac` out 1: accumulator load.
- `wr` out 1: memory write strobe.
- `data_e` out 1: accumulator-to-data-bus output enable.
- `halt` out 1: processor halted.
- `phase` out 3: current phase, for debug and bench use.

## Operation

Opcodes:
- HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = (opcode is ADD, AND, XOR or LDA).

State:
- A 3-bit `phase` register.
- A `halted` flag.
- While `halted`=0, `phase` increments by 1 every cycle and wraps 7→0.

Output decode, with all unlisted outputs at 0:
- 0 INST_ADDR: `sel`=1.
- 1 INST_FETCH: `sel`=1, `rd`=1.
- 2 INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
- 3 IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
- 4 OP_ADDR: `inc_pc`=1; `halt`=(opcode==HLT).
- 5 OP_FETCH: `rd`=ALUOP.
- 6 ALU_OP: `rd`=ALUOP; `inc_pc`=(SKZ && `zero`); `ld_pc`=JMP; `data_e`=STO.
- 7 STORE: `rd`=ALUOP; `ld_ac`=ALUOP; `inc_pc`=JMP; `ld_pc`=JMP; `wr`=STO; `data_e`=STO.

Halt:
- In OP_ADDR with opcode==HLT, `halted` is set at the next edge and `phase` stays at 4.
- While `halted`=1, every output is 0 except `halt`=1.
- `phase` holds at 4.
- `opcode` and `zero` are ignored.
- Only `rst` clears `halted`.

Reset:
- `rst`=1 at an edge sets `phase`=0 and `halted`=0, regardless of the current phase or halt state.
- `rst` overrides a halt decoded in the same cycle.
- While `rst` is held, `phase` stays 0 and the outputs show the INST_ADDR decode.

Inputs:
- `opcode` is treated as valid from phase 4 onward, because the IR is loaded by the end of phase 3.
- `zero` is sampled combinationally in phase 6 only.

## Timing

- One instruction takes exactly 8 cycles. The next instruction's INST_ADDR follows STORE with no bubble.
- All outputs are combinational from registered state. Downstream registers capture on the same rising edge that ends the phase.
- Reset values (after an `rst` edge):
  - `phase`=0 and `sel`=1.
  - `rd`, `ld_ir`, `inc_pc`, `ld_pc`, `ld_ac`, `wr`, `data_e` and `halt` are all 0.
- HLT timing:
  - `halt` first rises in phase 4 of the HLT instruction, together with `inc_pc`=1 for that single cycle.
  - From the next cycle on, `halt`=1 is held and `inc_pc`=0.
- SKZ with `zero`=1 gives two PC increments in one instruction: phase 4 and phase 6.
- JMP in phase 7 asserts `inc_pc` and `ld_pc` together. The PC gives load priority.

## Test plan

1. Reset sequence: `rst`=1 for 2 cycles, then 0, with `opcode`=2 (ADD) → `phase` steps 0,1,…,7,0.
   - Phase 0: `sel`=1, all other strobes 0.
   - Phase 2: `ld_ir`=1.
   - Phase 7: `ld_ac`=1 and `rd`=1.
2. STO (`opcode`=6) → `data_e`=1 in phases 6 and 7, `wr`=1 in phase 7 only, and `rd`=0 in phases 5–7.
3. SKZ (`opcode`=1):
   - `zero`=1 → `inc_pc`=1 in phase 4 and phase 6.
   - `zero`=0 → `inc_pc`=1 in phase 4 only.
4. JMP (`opcode`=7) → `ld_pc`=1 in phases 6 and 7, `inc_pc`=1 in phases 4 and 7, and `ld_ac`=0 throughout.
5. HLT (`opcode`=0):
   - Phase 4: `halt`=1 and `inc_pc`=1.
   - For the next 10 cycles: `phase`=4, `halt`=1, all other outputs 0, even with `opcode` changed to 2 and `zero` toggled.
   - Then `rst`=1 for one cycle → `phase`=0 and `halt`=0.
6. Reset mid-instruction: assert `rst` during phase 5 → the next cycle shows `phase`=0 with the INST_ADDR decode; after release, a full 8-phase cycle resumes.

Source files
------------

// File: rtl/controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit RISC core.
// Strobes are decoded Moore-style from the registered phase, the IR opcode and the ALU zero flag.
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;
  logic       alu_op;
  logic       is_hlt, is_skz, is_sto, is_jmp;

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  // State register; reset wins over a halt decoded in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: free-running phase counter that parks at OP_ADDR once halted.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      phase_d  = phase_q;
      halted_d = 1'b1;
    end else if ((phase_q == PH_OP_ADDR) && is_hlt) begin
      phase_d  = PH_OP_ADDR;
      halted_d = 1'b1;
    end else begin
      phase_d  = phase_q + 3'd1;
      halted_d = 1'b0;
    end
  end

  // Output decode per phase; a halted core shows only halt.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        PH_OP_FETCH: begin
          rd = alu_op;
        end
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the instruction sequencer: reset, each opcode class, halt and mid-instruction reset.
module tb_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobe vectors, bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  localparam logic [8:0] E_P0   = 9'b100000000;
  localparam logic [8:0] E_P1   = 9'b110000000;
  localparam logic [8:0] E_P23  = 9'b111000000;
  localparam logic [8:0] E_INC  = 9'b000100000;
  localparam logic [8:0] E_NONE = 9'b000000000;
  localparam logic [8:0] E_RD   = 9'b010000000;
  localparam logic [8:0] E_ADD7 = 9'b010001000;
  localparam logic [8:0] E_STO6 = 9'b000000010;
  localparam logic [8:0] E_STO7 = 9'b000000110;
  localparam logic [8:0] E_JMP6 = 9'b000010000;
  localparam logic [8:0] E_JMP7 = 9'b000110000;
  localparam logic [8:0] E_HLT4 = 9'b000100001;
  localparam logic [8:0] E_HLTD = 9'b000000001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_ph, input logic [8:0] exp_out);
    logic [11:0] obs;
    logic [11:0] expv;
    obs  = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    expv = {exp_ph, exp_out};
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s: observed phase/strobes=%b expected=%b", tag, obs, expv);
      end
  endtask

  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] ev [8];
    opcode = op;
    zero   = z;
    ev[0] = E_P0;  ev[1] = E_P1;  ev[2] = E_P23; ev[3] = E_P23;
    ev[4] = e4;    ev[5] = e5;    ev[6] = e6;    ev[7] = e7;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("%s_ph%0d", tag, p), p[2:0], ev[p]);
      step();
    end
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    step();
    step();
    chk("reset_hold", 3'd0, E_P0);
    rst = 1'b0;

    run_instr("add", 3'd2, 1'b0, E_INC, E_RD, E_RD, E_ADD7);
    run_instr("sto", 3'd6, 1'b0, E_INC, E_NONE, E_STO6, E_STO7);
    run_instr("skz_z1", 3'd1, 1'b1, E_INC, E_NONE, E_INC, E_NONE);
    run_instr("skz_z0", 3'd1, 1'b0, E_INC, E_NONE, E_NONE, E_NONE);
    run_instr("jmp", 3'd7, 1'b1, E_INC, E_NONE, E_JMP6, E_JMP7);
    run_instr("lda", 3'd5, 1'b0, E_INC, E_RD, E_RD, E_ADD7);

    // HLT: halt decoded in phase 4, then parked with only halt high
    opcode = 3'd0;
    zero   = 1'b0;
    chk("hlt_ph0", 3'd0, E_P0);
    repeat (4) step();
    chk("hlt_ph4", 3'd4, E_HLT4);
    step();
    opcode = 3'd2;
    for (int i = 0; i < 10; i++) begin
      zero = ~zero;
      chk($sformatf("halted_%0d", i), 3'd4, E_HLTD);
      step();
    end
    rst = 1'b1;
    step();
    chk("halt_reset", 3'd0, E_P0);
    rst = 1'b0;
    step();
    chk("post_halt_ph1", 3'd1, E_P1);

    // Reset in the same cycle a halt is decoded must win
    opcode = 3'd0;
    repeat (3) step();
    chk("hlt_race_ph4", 3'd4, E_HLT4);
    rst = 1'b1;
    step();
    chk("hlt_race_rst", 3'd0, E_P0);
    rst = 1'b0;
    step();
    chk("hlt_race_ph1", 3'd1, E_P1);

    // Reset mid-instruction during phase 5
    opcode = 3'd2;
    repeat (4) step();
    chk("mid_ph5", 3'd5, E_RD);
    rst = 1'b1;
    step();
    chk("mid_rst", 3'd0, E_P0);
    step();
    chk("mid_rst_held", 3'd0, E_P0);
    rst = 1'b0;
    run_instr("resume", 3'd2, 1'b0, E_INC, E_RD, E_RD, E_ADD7);
    chk("wrap_ph0", 3'd0, E_P0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
